// File: rtl/nn_event_pkg.sv
// rtl/nn_event_pkg.sv - shared widths, event record and helpers for the spike event encoder
package nn_event_pkg;

    function automatic int addr_width(input int num_cols);
        return (num_cols > 1) ? $clog2(num_cols) : 1;
    endfunction

    function automatic logic [31:0] drop_sat(input int width);
        return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    endfunction

    localparam int DEF_NUM_COLS = 1;
    localparam int DEF_TS_WIDTH = 16;
    localparam int DEF_ADDR_W   = addr_width(DEF_NUM_COLS);

    // Event record of the default build; the encoder packs the same layout at its own widths.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0]   addr;
        logic [DEF_TS_WIDTH-1:0] tstamp;
    } spike_event_t;

endpackage

// File: rtl/spike_event_encoder_if.sv
// rtl/spike_event_encoder_if.sv - address-event readout stream
interface spike_event_encoder_if #(
    parameter int ADDR_W   = 1,
    parameter int TS_WIDTH = 16
);
    logic                event_valid;
    logic                event_ready;
    logic [ADDR_W-1:0]   event_addr;
    logic [TS_WIDTH-1:0] event_time;

    modport master (output event_valid, output event_addr, output event_time, input event_ready);
    modport slave  (input event_valid, input event_addr, input event_time, output event_ready);
endinterface

// File: rtl/event_fifo.sv
// rtl/event_fifo.sv - synchronous FIFO with exact registered occupancy
module event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_LEVEL = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (level == '0);
    assign full     = (level == FULL_LEVEL);
    assign do_pop   = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts a push.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/spike_event_encoder.sv
// rtl/spike_event_encoder.sv - turns per-column spike pulses into timestamped address-events
module spike_event_encoder
    import nn_event_pkg::*;
#(
    parameter int NUM_COLS   = 1,
    parameter int TS_WIDTH   = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int DROP_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_COLS-1:0]         output_spike,
    spike_event_encoder_if.master       evt,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [DROP_WIDTH-1:0]       drop_count
);
    localparam int ADDR_W = addr_width(NUM_COLS);
    localparam int CNT_W  = $clog2(NUM_COLS + 1);
    localparam int SUM_W  = ((DROP_WIDTH > CNT_W) ? DROP_WIDTH : CNT_W) + 1;
    localparam logic [DROP_WIDTH-1:0] DROP_SAT = DROP_WIDTH'(drop_sat(DROP_WIDTH));

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [TS_WIDTH-1:0] tstamp;
    } event_word_t;

    logic [TS_WIDTH-1:0] ts_counter;
    logic [TS_WIDTH-1:0] ts_latch [NUM_COLS];
    logic [NUM_COLS-1:0] pending;
    logic [NUM_COLS-1:0] sel_onehot;
    logic [NUM_COLS-1:0] clear_mask;
    logic [NUM_COLS-1:0] lost;
    logic                sel_valid;
    logic [ADDR_W-1:0]   sel_idx;
    logic [TS_WIDTH-1:0] sel_ts;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    event_word_t         push_word;
    event_word_t         head_word;
    logic [CNT_W-1:0]    lost_count;
    logic [SUM_W-1:0]    drop_sum;
    logic [DROP_WIDTH-1:0] drop_next;

    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        sel_ts    = '0;
        for (int j = NUM_COLS - 1; j >= 0; j--) begin
            if (pending[j]) begin
                sel_valid = 1'b1;
                sel_idx   = ADDR_W'(j);
                sel_ts    = ts_latch[j];
            end
        end
    end

    assign sel_onehot = pending & (~pending + NUM_COLS'(1));
    assign pop        = evt.event_valid & evt.event_ready;
    assign push       = sel_valid & (~full | pop);
    assign clear_mask = push ? sel_onehot : '0;
    // A column whose pending bit is released this cycle re-arms instead of dropping.
    assign lost       = output_spike & pending & ~clear_mask;

    assign push_word.addr   = sel_idx;
    assign push_word.tstamp = sel_ts;

    always_comb begin
        lost_count = '0;
        for (int j = 0; j < NUM_COLS; j++) begin
            lost_count = lost_count + CNT_W'(lost[j]);
        end
        drop_sum  = SUM_W'(drop_count) + SUM_W'(lost_count);
        drop_next = (drop_sum > SUM_W'(DROP_SAT)) ? DROP_SAT : drop_sum[DROP_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_counter <= '0;
            pending    <= '0;
            drop_count <= '0;
            for (int j = 0; j < NUM_COLS; j++) begin
                ts_latch[j] <= '0;
            end
        end else begin
            ts_counter <= ts_counter + 1'b1;
            pending    <= (pending & ~clear_mask) | output_spike;
            drop_count <= drop_next;
            for (int j = 0; j < NUM_COLS; j++) begin
                if (output_spike[j] && !lost[j]) ts_latch[j] <= ts_counter;
            end
        end
    end

    event_fifo #(
        .WIDTH ($bits(event_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .pop_data  (head_word),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    // FIFO storage is not reset, so the head is masked to zero whenever nothing is buffered.
    assign evt.event_valid = ~empty;
    assign evt.event_addr  = empty ? '0 : head_word.addr;
    assign evt.event_time  = empty ? '0 : head_word.tstamp;

endmodule

// File: tb/tb_spike_event_encoder.sv
// tb/tb_spike_event_encoder.sv - randomized and directed checks of spike_event_encoder against a queue model
module tb_spike_event_encoder;

    logic       clk;
    logic       reset;
    logic [3:0] output_spike;
    logic       ready;
    logic [4:0] level_a, level_b;
    logic [7:0] drop_a, drop_b;

    int n_checks = 0;
    int n_fail   = 0;

    spike_event_encoder_if #(.ADDR_W(2), .TS_WIDTH(16)) ev_a ();
    spike_event_encoder_if #(.ADDR_W(2), .TS_WIDTH(4))  ev_b ();

    assign ev_a.event_ready = ready;
    assign ev_b.event_ready = ready;

    spike_event_encoder #(.NUM_COLS(4), .TS_WIDTH(16), .FIFO_DEPTH(16), .DROP_WIDTH(8)) dut_a (
        .clk          (clk),
        .reset        (reset),
        .output_spike (output_spike),
        .evt          (ev_a),
        .fifo_level   (level_a),
        .drop_count   (drop_a)
    );

    spike_event_encoder #(.NUM_COLS(4), .TS_WIDTH(4), .FIFO_DEPTH(16), .DROP_WIDTH(8)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .output_spike (output_spike),
        .evt          (ev_b),
        .fifo_level   (level_b),
        .drop_count   (drop_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int t;
    } mevt_t;

    mevt_t q[$];
    bit    pend[4];
    int    lat[4];
    int    drop_m;
    int    ts_m;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        for (int j = 0; j < 4; j++) begin
            pend[j] = 1'b0;
            lat[j]  = 0;
        end
        drop_m = 0;
        ts_m   = 0;
    endtask

    task automatic compare_all();
        bit v;
        v = (q.size() > 0);
        check_eq("valid_a", 32'(ev_a.event_valid), 32'(v));
        check_eq("valid_b", 32'(ev_b.event_valid), 32'(v));
        check_eq("level_a", 32'(level_a), 32'(q.size()));
        check_eq("level_b", 32'(level_b), 32'(q.size()));
        check_eq("drop_a", 32'(drop_a), 32'(drop_m));
        check_eq("drop_b", 32'(drop_b), 32'(drop_m));
        if (v) begin
            check_eq("addr_a", 32'(ev_a.event_addr), 32'(q[0].addr));
            check_eq("time_a", 32'(ev_a.event_time), 32'(q[0].t & 16'hFFFF));
            check_eq("addr_b", 32'(ev_b.event_addr), 32'(q[0].addr));
            check_eq("time_b", 32'(ev_b.event_time), 32'(q[0].t & 4'hF));
        end else if (!reset) begin
            check_eq("rst_addr_a", 32'(ev_a.event_addr), 32'd0);
            check_eq("rst_time_a", 32'(ev_a.event_time), 32'd0);
            check_eq("rst_time_b", 32'(ev_b.event_time), 32'd0);
        end
    endtask

    // Advance one clock: the model consumes the inputs presented this cycle, then outputs are compared.
    task automatic tick();
        bit pop;
        bit push;
        int sel;
        if (!reset) begin
            model_clear();
        end else begin
            sel  = -1;
            pop  = (q.size() > 0) && ready;
            for (int j = 3; j >= 0; j--) if (pend[j]) sel = j;
            push = (sel >= 0) && ((q.size() < 16) || pop);
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back('{sel, lat[sel]});
                pend[sel] = 1'b0;
            end
            for (int j = 0; j < 4; j++) begin
                if (output_spike[j]) begin
                    if (!pend[j]) begin
                        pend[j] = 1'b1;
                        lat[j]  = ts_m;
                    end else if (drop_m < 255) begin
                        drop_m++;
                    end
                end
            end
            ts_m = (ts_m + 1) & 16'hFFFF;
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int prev;
        reset        = 1'b0;
        output_spike = '0;
        ready        = 1'b0;
        model_clear();
        ticks(2);
        reset = 1'b1;

        // single spike on column 2 in cycle 5
        ready = 1'b1;
        ticks(5);
        output_spike = 4'b0100;
        tick();
        output_spike = '0;
        tick();
        check_eq("single_valid", 32'(ev_a.event_valid), 32'd1);
        check_eq("single_addr", 32'(ev_a.event_addr), 32'd2);
        check_eq("single_time", 32'(ev_a.event_time), 32'd5);
        tick();
        check_eq("single_done", 32'(ev_a.event_valid), 32'd0);

        // columns 0,1,3 together in cycle 10
        ticks(2);
        output_spike = 4'b1011;
        tick();
        output_spike = '0;
        tick();
        check_eq("multi_addr0", 32'(ev_a.event_addr), 32'd0);
        check_eq("multi_time0", 32'(ev_a.event_time), 32'd10);
        tick();
        check_eq("multi_addr1", 32'(ev_a.event_addr), 32'd1);
        tick();
        check_eq("multi_addr3", 32'(ev_a.event_addr), 32'd3);
        check_eq("multi_time3", 32'(ev_a.event_time), 32'd10);
        ticks(2);

        // back-pressure: column 0 every cycle with the consumer stalled
        ready        = 1'b0;
        output_spike = 4'b0001;
        ticks(25);
        output_spike = '0;
        check_eq("bp_level", 32'(level_a), 32'd16);
        check_eq("bp_drop", 32'(drop_a), 32'd8);
        ready = 1'b1;
        cnt   = 0;
        prev  = -1;
        for (int k = 0; k < 40; k++) begin
            if (ev_a.event_valid) begin
                if (cnt > 0) check_eq("bp_inc", 32'(int'(ev_a.event_time) > prev), 32'd1);
                prev = int'(ev_a.event_time);
                cnt++;
            end
            tick();
        end
        check_eq("bp_count", 32'(cnt), 32'd17);

        // column 1 on two consecutive cycles with an empty FIFO
        prev = drop_m;
        output_spike = 4'b0010;
        ticks(2);
        output_spike = '0;
        ticks(4);
        check_eq("setclr_drop", 32'(drop_a), 32'(prev));

        // timestamp wrap on the 4-bit instance: spikes at counter 15 and 0
        while ((ts_m & 15) != 15) tick();
        output_spike = 4'b0001;
        ticks(2);
        output_spike = '0;
        check_eq("wrap_t15", 32'(ev_b.event_time), 32'd15);
        tick();
        check_eq("wrap_t0", 32'(ev_b.event_time), 32'd0);
        ticks(3);

        // random traffic with stall phases
        for (int i = 0; i < 400; i++) begin
            if ((i % 80) < 20) ready = 1'b0;
            else               ready = ($urandom_range(0, 3) != 0);
            output_spike = 4'($urandom) & 4'($urandom);
            tick();
        end
        output_spike = '0;
        ready        = 1'b1;
        ticks(20);

        // drop counter saturation
        ready        = 1'b0;
        output_spike = 4'hF;
        ticks(100);
        output_spike = '0;
        check_eq("sat_drop_a", 32'(drop_a), 32'd255);
        check_eq("sat_drop_b", 32'(drop_b), 32'd255);
        ready = 1'b1;
        ticks(24);

        // asynchronous reset while events are draining
        ready        = 1'b0;
        output_spike = 4'b0101;
        ticks(5);
        output_spike = '0;
        ready        = 1'b1;
        tick();
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst_valid", 32'(ev_a.event_valid), 32'd0);
        check_eq("arst_level", 32'(level_a), 32'd0);
        check_eq("arst_drop", 32'(drop_a), 32'd0);
        ticks(2);
        reset        = 1'b1;
        output_spike = 4'b1000;
        tick();
        output_spike = '0;
        tick();
        check_eq("arst_ts0_addr", 32'(ev_a.event_addr), 32'd3);
        check_eq("arst_ts0_time", 32'(ev_a.event_time), 32'd0);
        ticks(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spike_event_encoder.md
Name: spike_event_encoder

Overview:
- Consumes the per-column output_spike pulses of the neuron array, one bit per neuron column.
- Converts each pulse into an address-event: column index plus capture timestamp.
- Buffers events in a FIFO and presents them on a valid/ready stream to the readout link.
- Sits directly downstream of the neuron columns in the nn top level.

Parameters:
- NUM_COLS, 1, number of neuron columns (spike input bits).
- TS_WIDTH, 16, timestamp width in bits.
- FIFO_DEPTH, 16, event FIFO depth; power of two, at least 2.
- DROP_WIDTH, 8, width of the saturating dropped-spike counter.

Ports:
- clk  in  1  main clock (sys_if.main_clk).
- reset  in  1  asynchronous, active-low reset.
- output_spike  in  NUM_COLS  neuron spike pulses; bit j = column j; sampled every rising clk edge.
- event_valid  out  1  FIFO head holds an event.
- event_ready  in  1  consumer accepts the head event.
- event_addr  out  ADDR_W  column index of the head event; ADDR_W = max(1, $clog2(NUM_COLS)).
- event_time  out  TS_WIDTH  timestamp of the head event.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- drop_count  out  DROP_WIDTH  saturating count of lost spikes.

Behaviour:
- Reset (reset=0, asynchronous) clears everything; deasserting reset (reset=1) releases it:
  - ts_counter=0, pending=0, per-column ts_latch=0, FIFO empty.
  - event_valid=0, event_addr=0, event_time=0, fifo_level=0, drop_count=0.
  - Reset mid-operation discards all pending and buffered events. No partial event may appear after release.
- Timestamp:
  - ts_counter increments every cycle and wraps from 2^TS_WIDTH-1 to 0.
  - The first cycle after reset release has value 0.
- Capture stage, at each edge for each column j with output_spike[j]=1:
  - If pending[j]=0, or pending[j] is being cleared this cycle: set pending[j]=1 and ts_latch[j]=ts_counter. This is not a drop.
  - Else: spike lost; drop_count increments, saturating at 2^DROP_WIDTH-1.
  - Multiple simultaneous losses in one cycle add their popcount, with saturation.
- Select stage:
  - Each cycle a fixed-priority encoder picks the lowest-index set pending bit.
  - If FIFO not full, or a pop occurs in the same cycle: push {j, ts_latch[j]} and clear pending[j].
  - If FIFO full with no pop: nothing is pushed and pending holds; no drop occurs at this stage.
  - Throughput: one event per cycle.
- Latency: a spike sampled at edge N is pushed at edge N+1. With an empty FIFO, event_valid=1 after edge N+1 (two cycles from spike presentation). event_time = ts_counter value in the cycle before edge N.
- Output handshake:
  - Transfer occurs on an edge where event_valid & event_ready.
  - event_addr and event_time stay stable while event_valid=1 and event_ready=0.
  - event_ready is ignored while event_valid=0.
- FIFO boundaries:
  - Simultaneous push and pop when full: allowed, level unchanged.
  - Simultaneous push and pop when empty: the pushed event appears next cycle; no bypass.
  - Read and write pointers wrap modulo FIFO_DEPTH. fifo_level is registered and exact.

Decomposition:
- Package nn_event_pkg holds:
  - function addr_width(NUM_COLS);
  - typedef spike_event_t, a packed struct {addr, time} parameterised via localparams;
  - DROP_SAT constant helper.
- Sub-module event_fifo: synchronous FIFO, parameters WIDTH and DEPTH; ports push/pop/full/empty/level. Instantiated once.
- Pending/priority/timestamp logic stays in spike_event_encoder.

Test Plan:
- Single spike, NUM_COLS=4, event_ready=1: pulse bit2 in cycle 5 after reset release -> one event addr=2, time=5, valid cycles 7..7; drop_count=0.
- Simultaneous spikes: bits 0,1,3 high in cycle 10, ready=1 -> events addr 0,1,3 in consecutive cycles 12,13,14, all time=10.
- Back-pressure and drop: ready=0, bit0 pulsed every cycle for 25 cycles, FIFO_DEPTH=16:
  - fifo_level reaches 16; pending[0] holds.
  - Later pulses -> drop_count=8.
  - Raise ready -> 17 events drain in order with strictly increasing times; no reorder.
- Timestamp wrap, TS_WIDTH=4: spikes at ts_counter values 15 and 0 -> event_time 15 then 0.
- Set/clear same cycle: bit1 pulsed in two consecutive cycles with FIFO empty -> two events addr=1, times t and t+1; drop_count=0.
- Asynchronous reset mid-drain: 5 events queued, reset=0 between edges -> event_valid=0 immediately; after release fifo_level=0, drop_count=0, ts restarts at 0.
